// File: rtl/local_branch_predictor_if.sv
// Lookup/predict, resolve/update and evict bundle for local_branch_predictor.
// master: fetch/resolve side (drives requests); slave: predictor (drives pred_*, busy).
interface local_branch_predictor_if #(
  parameter int PC_W   = 10,
  parameter int IDX_W  = 3,
  parameter int HIST_W = 3
);
  logic              lookup_valid;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [HIST_W-1:0] upd_hist;
  logic              evict;
  logic [IDX_W-1:0]  evict_idx;
  logic              busy;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_taken, upd_hist,
    output evict, evict_idx,
    input  pred_valid, pred_taken, pred_hist, busy
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_taken, upd_hist,
    input  evict, evict_idx,
    output pred_valid, pred_taken, pred_hist, busy
  );
endinterface

// File: rtl/local_branch_predictor.sv
// Two-level local-history branch predictor with post-reset sweep and evict.
// Ports: clk, rst (sync, active-high), bus (local_branch_predictor_if.slave).
// Option: define LBP_BYPASS_EN to forward same-cycle writes to the lookup.
module local_branch_predictor #(
  parameter int PC_W   = 10,
  parameter int IDX_W  = 3,
  parameter int HIST_W = 3,
  parameter int CTR_W  = 2
) (
  input  logic clk,
  input  logic rst,
  local_branch_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int ROWS    = 1 << HIST_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W-1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [CTR_W-1:0]  ctr  [ENTRIES][ROWS];
  logic [HIST_W-1:0] hist [ENTRIES];

  logic              acc, lk_en, up_en, ev_en;
  logic [IDX_W-1:0]  li, uj;
  logic [HIST_W:0]   uh_shift;
  logic [HIST_W-1:0] uh_new;
  logic [CTR_W-1:0]  uc_old, uc_new;
  logic              up_drop;
  logic              lk_taken;
  logic [HIST_W-1:0] lk_hist;
  logic              pv_q, pt_q;
  logic [HIST_W-1:0] ph_q;

  if (PC_W > IDX_W) begin : g_unused
    logic unused_pc;
    assign unused_pc = ^{bus.lookup_pc[PC_W-1:IDX_W],
                         bus.upd_pc[PC_W-1:IDX_W]};
  end

  assign acc   = (state_q == IDLE) && !rst;
  assign lk_en = acc && bus.lookup_valid;
  assign up_en = acc && bus.upd_valid;
  assign ev_en = acc && bus.evict;

  assign li = bus.lookup_pc[IDX_W-1:0];
  assign uj = bus.upd_pc[IDX_W-1:0];

  // History shifts in the outcome on top of the stored history.
  assign uh_shift = {hist[uj], bus.upd_taken};
  assign uh_new   = uh_shift[HIST_W-1:0];
  assign uc_old   = ctr[uj][bus.upd_hist];
  // Evict on the same entry overrides the update.
  assign up_drop  = ev_en && (bus.evict_idx == uj);

  always_comb begin
    uc_new = uc_old;
    if (bus.upd_taken) begin
      if (uc_old != CTR_MAX) uc_new = uc_old + 1'b1;
    end else begin
      if (uc_old != '0) uc_new = uc_old - 1'b1;
    end
  end

  always_comb begin
    lk_hist  = hist[li];
    lk_taken = ctr[li][hist[li]][CTR_W-1];
`ifdef LBP_BYPASS_EN
    if (ev_en && bus.evict_idx == li) begin
      lk_hist  = '0;
      lk_taken = CTR_INIT[CTR_W-1];
    end else if (up_en && uj == li) begin
      lk_hist  = uh_new;
      lk_taken = (uh_new == bus.upd_hist) ?
                 uc_new[CTR_W-1] :
                 ctr[li][uh_new][CTR_W-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      SWEEP: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IDX_LAST) state_d = IDLE;
      end
      IDLE: ;
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      sweep_q <= '0;
      pv_q    <= 1'b0;
      pt_q    <= 1'b0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      pv_q    <= lk_en;
      if (lk_en) begin
        pt_q <= lk_taken;
        ph_q <= lk_hist;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == SWEEP) begin
        hist[sweep_q] <= '0;
        for (int k = 0; k < ROWS; k++)
          ctr[sweep_q][k] <= CTR_INIT;
      end else begin
        if (up_en && !up_drop) begin
          ctr[uj][bus.upd_hist] <= uc_new;
          hist[uj]              <= uh_new;
        end
        if (ev_en) begin
          hist[bus.evict_idx] <= '0;
          for (int k = 0; k < ROWS; k++)
            ctr[bus.evict_idx][k] <= CTR_INIT;
        end
      end
    end
  end

  assign bus.pred_valid = pv_q;
  assign bus.pred_taken = pt_q;
  assign bus.pred_hist  = ph_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_local_branch_predictor.sv
// Bench for local_branch_predictor: directed vector table, reset/sweep
// sequences and random traffic against a table-level reference model.
module tb_local_branch_predictor;
  localparam int PC_W = 10, IDX_W = 3, HIST_W = 3, CTR_W = 2;
  localparam int ENT = 8, ROWS = 8, CMAX = 3, CINIT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  local_branch_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();

  local_branch_predictor #(
    .PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit         lv;
    logic [9:0] lpc;
    bit         uv;
    logic [9:0] upc;
    bit         ut;
    logic [2:0] uh;
    bit         ev;
    logic [2:0] ei;
    bit         epv;
    bit         ept;
    logic [2:0] eph;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int m_ctr [ENT][ROWS];
  int m_hist [ENT];
  int sweep_left = 0;
  bit seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit lv, int lpc, bit uv, int upc, bit ut,
                              int uh, bit ev, int ei,
                              bit epv, bit ept, int eph);
    vec_t v;
    v.lv = lv; v.lpc = 10'(lpc);
    v.uv = uv; v.upc = 10'(upc); v.ut = ut; v.uh = 3'(uh);
    v.ev = ev; v.ei = 3'(ei);
    v.epv = epv; v.ept = ept; v.eph = 3'(eph);
    return v;
  endfunction

  task automatic m_init();
    for (int e = 0; e < ENT; e++) begin
      m_hist[e] = 0;
      for (int r = 0; r < ROWS; r++) m_ctr[e][r] = CINIT;
    end
  endtask

  task automatic m_write(input vec_t v);
    int j;
    int c;
    j = int'(v.upc) % ENT;
    if (v.uv && !(v.ev && int'(v.ei) == j)) begin
      c = m_ctr[j][v.uh];
      if (v.ut) m_ctr[j][v.uh] = (c < CMAX) ? c + 1 : c;
      else      m_ctr[j][v.uh] = (c > 0) ? c - 1 : c;
      m_hist[j] = ((m_hist[j] * 2) + int'(v.ut)) % ROWS;
    end
    if (v.ev) begin
      m_hist[v.ei] = 0;
      for (int r = 0; r < ROWS; r++) m_ctr[v.ei][r] = CINIT;
    end
  endtask

  // One clock: drive, model the cycle, then check after the edge.
  task automatic cyc(input bit r, input vec_t v);
    bit epv;
    int ept, eph, i;
    rst              = r;
    bus.lookup_valid = v.lv;
    bus.lookup_pc    = v.lpc;
    bus.upd_valid    = v.uv;
    bus.upd_pc       = v.upc;
    bus.upd_taken    = v.ut;
    bus.upd_hist     = v.uh;
    bus.evict        = v.ev;
    bus.evict_idx    = v.ei;
    if (seen) chk("busy", int'(bus.busy), int'(sweep_left > 0));
    epv = 0; ept = 0; eph = 0;
    if (r) begin
      seen = 1;
      sweep_left = ENT;
      m_init();
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      i = int'(v.lpc) % ENT;
`ifdef LBP_BYPASS_EN
      m_write(v);
`endif
      if (v.lv) begin
        epv = 1;
        eph = m_hist[i];
        ept = (m_ctr[i][eph] >= 2) ? 1 : 0;
      end
`ifndef LBP_BYPASS_EN
      m_write(v);
`endif
    end
    @(posedge clk);
    #1;
    chk("pred_valid", int'(bus.pred_valid), int'(epv));
    if (epv) begin
      chk("pred_taken", int'(bus.pred_taken), ept);
      chk("pred_hist", int'(bus.pred_hist), eph);
    end
  endtask

  vec_t tbl[$];
  vec_t idle_v;

  initial begin
    int n;
    bit any_pv;
    vec_t v;
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.lookup_valid = 0; bus.lookup_pc = '0;
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0; bus.upd_hist = '0;
    bus.evict = 0; bus.evict_idx = '0;

    // Reset held 3 cycles, then sweep must last exactly ENT cycles.
    cyc(1, idle_v);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_pv", int'(bus.pred_valid), 0);
    chk("rst_pt", int'(bus.pred_taken), 0);
    chk("rst_ph", int'(bus.pred_hist), 0);
    cyc(1, idle_v);
    cyc(1, idle_v);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.busy) break;
      n++;
      cyc(0, idle_v);
    end
    chk("busy_len", n, ENT);

    //          lv lpc    uv upc    ut uh ev ei  epv pt ph
    tbl.push_back(mk(1, 10'h3FF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 2, 1, 10'h00D, 0, 3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 6, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 1, 0, 1, 6, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1));
`ifdef LBP_BYPASS_EN
    tbl.push_back(mk(1, 3, 1, 3, 1, 0, 0, 0, 1, 0, 1));
`else
    tbl.push_back(mk(1, 3, 1, 3, 1, 0, 0, 0, 1, 0, 0));
`endif
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1));

    foreach (tbl[k]) begin
      cyc(0, tbl[k]);
      chk($sformatf("v%0d_pv", k), int'(bus.pred_valid), int'(tbl[k].epv));
      if (tbl[k].epv) begin
        chk($sformatf("v%0d_pt", k), int'(bus.pred_taken), int'(tbl[k].ept));
        chk($sformatf("v%0d_ph", k), int'(bus.pred_hist), int'(tbl[k].eph));
      end
    end

    // Reset mid-sweep restarts it; lookups while busy are discarded.
    v = mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, idle_v);
    for (int k = 0; k < 4; k++) cyc(0, v);
    cyc(1, idle_v);
    n = 0;
    any_pv = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.busy) break;
      n++;
      cyc(0, v);
      if (bus.pred_valid) any_pv = 1;
    end
    chk("busy_len_restart", n, ENT);
    chk("pv_while_busy", int'(any_pv), 0);
    cyc(0, mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("post_sweep_ph", int'(bus.pred_hist), 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      v = idle_v;
      v.lv  = 1'($urandom_range(0, 1));
      v.lpc = 10'($urandom_range(0, 1023));
      v.uv  = 1'($urandom_range(0, 1));
      v.upc = 10'($urandom_range(0, 1023));
      v.ut  = 1'($urandom_range(0, 1));
      v.uh  = 3'($urandom_range(0, 7));
      v.ev  = ($urandom_range(0, 7) == 0);
      v.ei  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) v.upc = v.lpc;
      cyc(($urandom_range(0, 149) == 0), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
